// File: rtl/chess_movegen_seq.sv
// chess_movegen_seq: MVV-LVA capture sequencer that drives the board core command port.
// Streams (aggressor, victim) pairs best-capture-first. Finished victims are masked again after every ENABLE-ALL.
module chess_movegen_seq #(
  parameter int RESULT_LAT = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [7:0]       cmd_addr,
  output logic [7:0]       cmd_data,
  input  logic [7:0]       result,
  output logic             mv_valid,
  input  logic             mv_ready,
  output logic [5:0]       mv_from,
  output logic [5:0]       mv_to,
  output logic [CNT_W-1:0] mv_count
);

  localparam int WAIT_W = (RESULT_LAT > 1) ? $clog2(RESULT_LAT) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_EN_ALL, S_REPLAY, S_VSEARCH, S_VWAIT,
    S_ASEARCH, S_AWAIT, S_EMIT, S_ADIS, S_FIN
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [63:0]       r_done_mask, w_done_mask_nxt;
  logic [63:0]       r_shadow, w_shadow_nxt;
  logic [5:0]        r_victim, w_victim_nxt;
  logic [WAIT_W-1:0] r_wait, w_wait_nxt;
  logic              w_sample;
  logic [7:0]        r_cmd_addr, r_cmd_data, w_cmd_addr_nxt, w_cmd_data_nxt;
  logic              r_busy, r_done, r_mv_valid;
  logic              r_illegal, w_illegal_nxt;
  logic [5:0]        r_mv_from, r_mv_to, w_mv_from_nxt, w_mv_to_nxt;
  logic [CNT_W-1:0]  r_mv_count, w_mv_count_nxt;

  function automatic logic [15:0] f_sq_cmd(input logic [3:0] op, input logic [5:0] sq);
    return {op, 2'b00, sq[5:4], sq[3:0], 4'h0};
  endfunction

  function automatic logic [5:0] f_lowest(input logic [63:0] m);
    logic [5:0] idx;
    idx = '0;
    for (int i = 63; i >= 0; i--) if (m[i]) idx = 6'(i);
    return idx;
  endfunction

  always_comb begin
    w_state_nxt     = r_state;
    w_done_mask_nxt = r_done_mask;
    w_shadow_nxt    = r_shadow;
    w_victim_nxt    = r_victim;
    w_wait_nxt      = '0;
    w_illegal_nxt   = r_illegal;
    w_mv_from_nxt   = r_mv_from;
    w_mv_to_nxt     = r_mv_to;
    w_mv_count_nxt  = r_mv_count;
    w_sample        = (r_wait == WAIT_W'(RESULT_LAT - 1));
    w_cmd_addr_nxt  = 8'h00;
    w_cmd_data_nxt  = 8'h00;

    case (r_state)
      S_IDLE: if (start) begin
        w_done_mask_nxt = '0;
        w_mv_count_nxt  = '0;
        w_illegal_nxt   = 1'b0;
        w_state_nxt     = S_EN_ALL;
      end
      S_EN_ALL: begin
        w_shadow_nxt = r_done_mask;
        w_state_nxt  = S_REPLAY;
      end
      // The bit on show this cycle is the lowest one; drop it and leave once nothing is left.
      S_REPLAY: begin
        w_shadow_nxt = r_shadow & (r_shadow - 64'd1);
        if (w_shadow_nxt == '0) w_state_nxt = S_VSEARCH;
      end
      S_VSEARCH: w_state_nxt = S_VWAIT;
      S_VWAIT: begin
        if (w_sample) begin
          if (result[7]) begin
            w_illegal_nxt = 1'b1;
            w_state_nxt   = S_FIN;
          end else if (result[6]) begin
            w_state_nxt = S_FIN;
          end else begin
            w_victim_nxt = result[5:0];
            w_state_nxt  = S_ASEARCH;
          end
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      S_ASEARCH: w_state_nxt = S_AWAIT;
      S_AWAIT: begin
        if (w_sample) begin
          if (result[6]) begin
            w_done_mask_nxt[r_victim] = 1'b1;
            w_state_nxt               = S_EN_ALL;
          end else begin
            w_mv_from_nxt = result[5:0];
            w_mv_to_nxt   = r_victim;
            w_state_nxt   = S_EMIT;
          end
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      S_EMIT: if (r_mv_valid && mv_ready) begin
        if (r_mv_count != '1) w_mv_count_nxt = r_mv_count + CNT_W'(1);
        w_state_nxt = S_ADIS;
      end
      S_ADIS:  w_state_nxt = S_ASEARCH;
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase

    // abort wins over everything decided above, including a start seen in IDLE
    if (abort) begin
      w_state_nxt     = S_IDLE;
      w_done_mask_nxt = r_done_mask;
      w_illegal_nxt   = r_illegal;
      w_mv_count_nxt  = r_mv_count;
      w_mv_from_nxt   = r_mv_from;
      w_mv_to_nxt     = r_mv_to;
      w_wait_nxt      = '0;
    end

    // Command registers hold the command of the state being entered.
    case (w_state_nxt)
      S_EN_ALL:  w_cmd_addr_nxt = 8'hC0;
      S_REPLAY:  if (w_shadow_nxt != '0)
                   {w_cmd_addr_nxt, w_cmd_data_nxt} = f_sq_cmd(4'hD, f_lowest(w_shadow_nxt));
      S_VSEARCH: w_cmd_addr_nxt = 8'hE0;
      S_ASEARCH: {w_cmd_addr_nxt, w_cmd_data_nxt} = f_sq_cmd(4'hF, w_victim_nxt);
      S_ADIS:    {w_cmd_addr_nxt, w_cmd_data_nxt} = f_sq_cmd(4'hD, w_mv_from_nxt);
      default:   ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_done_mask <= '0;
      r_shadow    <= '0;
      r_victim    <= '0;
      r_wait      <= '0;
      r_cmd_addr  <= 8'h00;
      r_cmd_data  <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_illegal   <= 1'b0;
      r_mv_valid  <= 1'b0;
      r_mv_from   <= '0;
      r_mv_to     <= '0;
      r_mv_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_done_mask <= w_done_mask_nxt;
      r_shadow    <= w_shadow_nxt;
      r_victim    <= w_victim_nxt;
      r_wait      <= w_wait_nxt;
      r_cmd_addr  <= w_cmd_addr_nxt;
      r_cmd_data  <= w_cmd_data_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_done      <= (w_state_nxt == S_FIN);
      r_illegal   <= w_illegal_nxt;
      r_mv_valid  <= (w_state_nxt == S_EMIT);
      r_mv_from   <= w_mv_from_nxt;
      r_mv_to     <= w_mv_to_nxt;
      r_mv_count  <= w_mv_count_nxt;
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign illegal  = r_illegal;
  assign cmd_addr = r_cmd_addr;
  assign cmd_data = r_cmd_data;
  assign mv_valid = r_mv_valid;
  assign mv_from  = r_mv_from;
  assign mv_to    = r_mv_to;
  assign mv_count = r_mv_count;

endmodule

// File: tb/tb_chess_movegen_seq.sv
// Bench for chess_movegen_seq: a behavioural board core answers the commands, and an
// abstract capture-order model predicts the move stream, count and illegal flag.
module tb_chess_movegen_seq;
  localparam int RL = 1;
  localparam int CW = 8;

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, mv_ready = 1'b0;
  logic [7:0]    result = 8'h00;
  logic          busy, done, illegal, mv_valid;
  logic [7:0]    cmd_addr, cmd_data;
  logic [5:0]    mv_from, mv_to;
  logic [CW-1:0] mv_count;

  chess_movegen_seq #(.RESULT_LAT(RL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
    .illegal(illegal), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .result(result),
    .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_from(mv_from), .mv_to(mv_to),
    .mv_count(mv_count)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] f; logic [5:0] t; } mv_t;

  int n_chk = 0, n_pass = 0;
  // board scenario: victims in value order, attackers per victim in cheapest-first order
  bit [7:0]  vlist[$];
  bit [7:0]  att[64][$];
  int        ill_at = 0;
  bit [63:0] en = '1;
  int        vs_cnt = 0, cyc = 0, bad_cmd = 0;
  bit [7:0]  rsp_at[int];
  mv_t       exp_q[$];
  bit        exp_ill;
  int        exp_n;
  bit [7:0]  clog_a[$], clog_d[$];
  int        done_cnt = 0, n_moves = 0, n_stall = 0, rdy_mode = 0, stall = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, need 0x%0h", name, act, req);
  endtask

  function automatic bit [7:0] find_victim();
    if (ill_at != 0 && vs_cnt == ill_at) return 8'h80;
    foreach (vlist[i]) if (en[vlist[i][5:0]]) return vlist[i];
    return 8'h40;
  endfunction

  function automatic bit [7:0] find_aggr(input logic [5:0] v);
    foreach (att[v][j]) if (en[att[v][j][5:0]]) return att[v][j];
    return 8'h40;
  endfunction

  // Expected stream: each victim once in value order, its attackers in order, skipping
  // squares of victims already finished; the ill_at-th victim search reports illegal.
  task automatic build_expected();
    bit [63:0] d;
    int ns, vf;
    d = '0; ns = 0; exp_q.delete(); exp_ill = 1'b0;
    while (1) begin
      ns++;
      if (ill_at != 0 && ns == ill_at) begin exp_ill = 1'b1; break; end
      vf = -1;
      foreach (vlist[i]) if (vf < 0 && !d[vlist[i][5:0]]) vf = int'(vlist[i]);
      if (vf < 0) break;
      foreach (att[vf][j])
        if (!d[att[vf][j][5:0]]) exp_q.push_back(mv_t'({att[vf][j][5:0], vf[5:0]}));
      d[vf] = 1'b1;
    end
    exp_n = exp_q.size();
  endtask

  // board core: takes the command at mid-cycle, answers exactly RL cycles later
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (cmd_addr == 8'h00 && cmd_data != 8'h00) bad_cmd++;
      case (cmd_addr[7:4])
        4'h0: ;
        4'hC: en = '1;
        4'hD: en[{cmd_addr[1:0], cmd_data[7:4]}] = 1'b0;
        4'hE: begin vs_cnt++; rsp_at[cyc + RL] = find_victim(); end
        4'hF: rsp_at[cyc + RL] = find_aggr({cmd_addr[1:0], cmd_data[7:4]});
        default: bad_cmd++;
      endcase
    end
  end

  // result carries junk outside the answer cycle
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (rsp_at.exists(cyc)) begin result = rsp_at[cyc]; rsp_at.delete(cyc); end
    else result = 8'($urandom);
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: mv_ready = 1'b1;
      1: mv_ready = ($urandom_range(0, 2) != 0);
      default: if (mv_valid && stall < 5) begin mv_ready = 1'b0; stall++; end
               else begin mv_ready = mv_valid; stall = 0; end
    endcase
  end

  // compare process: move stream, hold under backpressure, quiet command port while offering
  initial begin
    mv_t m;
    bit p_stall;
    logic [5:0] p_from, p_to;
    p_stall = 1'b0; p_from = '0; p_to = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (busy) begin clog_a.push_back(cmd_addr); clog_d.push_back(cmd_data); end
        if (done) done_cnt++;
        if (mv_valid) chk("noop_while_valid", 32'({cmd_addr, cmd_data}), 32'h0);
        if (p_stall && mv_valid) begin
          chk("hold_from", 32'(mv_from), 32'(p_from));
          chk("hold_to", 32'(mv_to), 32'(p_to));
        end
        if (mv_valid && !mv_ready) n_stall++;
        p_stall = mv_valid && !mv_ready; p_from = mv_from; p_to = mv_to;
        if (mv_valid && mv_ready && !abort) begin
          n_moves++;
          if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL extra_move: got %0h->%0h, need no move", mv_from, mv_to);
          end else begin
            m = exp_q.pop_front();
            chk("mv_from", 32'(mv_from), 32'(m.f));
            chk("mv_to", 32'(mv_to), 32'(m.t));
          end
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run(input int rmode, input string tag);
    int n;
    build_expected();
    en = '1; vs_cnt = 0; bad_cmd = 0; done_cnt = 0; n_moves = 0; n_stall = 0;
    clog_a.delete(); clog_d.delete(); rdy_mode = rmode; stall = 0;
    pulse_start();
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_ill_clr"}, 32'(illegal), 32'd0);
    if (rmode == 1) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    n = 0;
    while (done_cnt == 0 && n < 3000) begin @(negedge clk); n++; end
    if (done_cnt == 0) begin
      n_chk++;
      $display("FAIL %s_timeout: no done after %0d cycles, need done", tag, n);
      rst = 1'b1; repeat (2) @(posedge clk); #1 rst = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_count"}, 32'(mv_count), 32'(exp_n));
    chk({tag, "_illegal"}, 32'(illegal), 32'(exp_ill));
    chk({tag, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_badcmd"}, 32'(bad_cmd), 32'd0);
  endtask

  task automatic clear_board();
    vlist.delete();
    foreach (att[s]) att[s].delete();
    ill_at = 0;
  endtask

  task automatic rand_scen();
    bit [63:0] used, u;
    int nv, na, s;
    bit [7:0] v;
    clear_board();
    used = '0;
    nv = $urandom_range(0, 4);
    for (int i = 0; i < nv; i++) begin
      do s = $urandom_range(0, 63); while (used[s]);
      used[s] = 1'b1;
      vlist.push_back(8'(s));
    end
    foreach (vlist[i]) begin
      v = vlist[i]; u = '0; u[v[5:0]] = 1'b1;
      na = $urandom_range(0, 3);
      for (int j = 0; j < na; j++) begin
        do s = ($urandom_range(0, 1) == 1) ? int'(vlist[$urandom_range(0, nv - 1)])
                                           : $urandom_range(0, 63);
        while (u[s]);
        u[s] = 1'b1;
        att[v[5:0]].push_back(8'(s));
      end
    end
    ill_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, nv + 1) : 0;
  endtask

  initial begin
    bit [15:0] e3[10];
    bit [7:0]  e2[4];
    int k, n;
    e3 = '{16'hC000, 16'hE000, 16'hF1C0, 16'hD0B0, 16'hF1C0,
           16'hD060, 16'hF1C0, 16'hC000, 16'hD1C0, 16'hE000};
    e2 = '{8'hC0, 8'h00, 8'hE0, 8'h00};

    // reset held three cycles
    repeat (3) @(posedge clk);
    #1;
    chk("rst_flags", 32'({busy, done, illegal, mv_valid}), 32'h0);
    chk("rst_cmd", 32'({cmd_addr, cmd_data}), 32'h0);
    chk("rst_move", 32'({mv_from, mv_to}), 32'h0);
    chk("rst_count", 32'(mv_count), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk("idle_busy", 32'(busy), 32'd0); end

    // empty board
    clear_board();
    run(0, "empty");
    if (clog_a.size() < 4) begin n_chk++; $display("FAIL empty_log: got %0d cmds, need 4", clog_a.size()); end
    else for (int i = 0; i < 4; i++) chk($sformatf("empty_cmd%0d", i), 32'(clog_a[i]), 32'(e2[i]));

    // victim e4 with two attackers
    clear_board();
    vlist.push_back(8'h1C); att[28].push_back(8'h0B); att[28].push_back(8'h06);
    run(0, "e4");
    chk("e4_model_n", 32'(exp_n), 32'd2);
    chk("e4_count_lit", 32'(mv_count), 32'd2);
    k = 0;
    foreach (clog_a[i]) if (clog_a[i] != 8'h00 || clog_d[i] != 8'h00) begin
      if (k < 10) chk($sformatf("e4_cmd%0d", k), 32'({clog_a[i], clog_d[i]}), 32'(e3[k]));
      k++;
    end
    chk("e4_cmd_cnt", 32'(k), 32'd10);

    // same position under five cycles of backpressure per move
    run(2, "bp");
    chk("bp_stalls", 32'(n_stall), 32'd10);

    // illegal position
    clear_board();
    vlist.push_back(8'h1C); att[28].push_back(8'h0B); ill_at = 1;
    run(1, "ill");
    chk("ill_moves", 32'(n_moves), 32'd0);
    repeat (5) @(negedge clk);
    chk("ill_hold", 32'(illegal), 32'd1);

    // abort while waiting on the aggressor answer
    ill_at = 0; exp_q.delete(); en = '1; vs_cnt = 0; done_cnt = 0; rdy_mode = 0;
    pulse_start();
    chk("ab_ill_clr", 32'(illegal), 32'd0);
    n = 0;
    while (cmd_addr[7:4] != 4'hF && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin n_chk++; $display("FAIL ab_find_aggr: got no FIND-AGGRESSOR, need one"); end
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_valid", 32'(mv_valid), 32'd0);
    chk("ab_cmd", 32'({cmd_addr, cmd_data}), 32'h0);
    repeat (3) @(negedge clk);
    chk("ab_no_done", 32'(done_cnt), 32'd0);
    run(0, "rs");
    if (clog_a.size() < 3) begin n_chk++; $display("FAIL rs_log: got %0d cmds, need 3", clog_a.size()); end
    else for (int i = 0; i < 3; i++) chk($sformatf("rs_cmd%0d", i), 32'(clog_a[i]), 32'(e2[i]));

    // randomized positions with random consumer stalls
    for (int r = 0; r < 40; r++) begin
      rand_scen();
      run(1, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
